// File: rtl/sn74ls165_rx.sv
// Receive side of a 165-style parallel-load serial link: rebuilds WIDTH-bit words
// from the shifted bit stream and holds them for a consumer with valid/ack, overrun and frame-error flags.
module sn74ls165_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             ld_n,
  input  logic             en_n,
  input  logic             si,
  input  logic             rd,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             ovr,
  output logic             frm_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Consumer handshake: q_valid rises on the edge that samples the last bit of a
  // word and falls on the first edge with rd=1; a word completing on an rd edge
  // replaces q and keeps q_valid high.
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic              ovr_q, ovr_d;
  logic              frm_err_q, frm_err_d;
  logic              ovr_set;
  logic [WIDTH-1:0]  word;

  // Word as it would look with the current si shifted in.
  assign word = MSB_FIRST ? {sreg_q[WIDTH-2:0], si} : {si, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    frm_err_d = 1'b0;
    ovr_set   = 1'b0;

    if (rd) q_valid_d = 1'b0;

    if (!ld_n) begin
      cnt_d   = '0;
      state_d = IDLE;
      sreg_d  = '0;
      if (state_q == SHIFT) frm_err_d = 1'b1;
    end else if (!en_n) begin
      sreg_d = word;
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
        if (!q_valid_q || rd) begin
          q_d       = word;
          q_valid_d = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = SHIFT;
      end
    end

    // A fresh overrun beats a simultaneous clear so it is never lost.
    ovr_d = ovr_set | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      ovr_q     <= ovr_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign ovr     = ovr_q;
  assign frm_err = frm_err_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_sn74ls165_rx.sv
// Directed bench for sn74ls165_rx: an MSB-first and an LSB-first receiver share one
// stimulus stream; a vector table covers the basic frame, then hand sequences cover the corners.
module tb_sn74ls165_rx;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       ld_n = 1'b1, en_n = 1'b1, si = 1'b0, rd = 1'b0, clr_ovr = 1'b0;
  logic [7:0] q_m, q_l;
  logic       qv_m, ovr_m, frm_m, busy_m;
  logic       qv_l, ovr_l, frm_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ck = ~ck;

  sn74ls165_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .ck(ck), .rst(rst), .ld_n(ld_n), .en_n(en_n), .si(si), .rd(rd), .clr_ovr(clr_ovr),
    .q(q_m), .q_valid(qv_m), .ovr(ovr_m), .frm_err(frm_m), .busy(busy_m)
  );

  sn74ls165_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .ck(ck), .rst(rst), .ld_n(ld_n), .en_n(en_n), .si(si), .rd(rd), .clr_ovr(clr_ovr),
    .q(q_l), .q_valid(qv_l), .ovr(ovr_l), .frm_err(frm_l), .busy(busy_l)
  );

  typedef struct {
    logic       ld_n, en_n, si, rd, clr;
    logic [7:0] q;
    logic       qv, ovr, frm, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic l, logic e, logic s, logic r, logic c,
                              logic [7:0] eq, logic eqv, logic eovr, logic efrm, logic ebusy);
    vec_t v;
    v.ld_n = l; v.en_n = e; v.si = s; v.rd = r; v.clr = c;
    v.q = eq; v.qv = eqv; v.ovr = eovr; v.frm = efrm; v.busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_msb(input string tag, input logic [7:0] eq, input logic eqv,
                         input logic eovr, input logic efrm, input logic ebusy);
    chk({tag, ".q"}, 32'(q_m), 32'(eq));
    chk({tag, ".q_valid"}, 32'(qv_m), 32'(eqv));
    chk({tag, ".ovr"}, 32'(ovr_m), 32'(eovr));
    chk({tag, ".frm_err"}, 32'(frm_m), 32'(efrm));
    chk({tag, ".busy"}, 32'(busy_m), 32'(ebusy));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic l, input logic e, input logic s, input logic r, input logic c);
    @(negedge ck);
    ld_n = l; en_n = e; si = s; rd = r; clr_ovr = c;
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Eight consecutive enabled edges, b[7] first on the wire.
  task automatic send_byte(input logic [7:0] b, input logic rd_last, input logic clr_last);
    for (int i = 7; i >= 0; i--)
      step(1'b1, 1'b0, b[i], (i == 0) ? rd_last : 1'b0, (i == 0) ? clr_last : 1'b0);
  endtask

  task automatic pulse_rst();
    @(negedge ck);
    ld_n = 1'b1; en_n = 1'b1; si = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
    rst = 1'b1;
    #1;
    @(negedge ck);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] words[3];

    // Reset state, checked while rst is still asserted.
    repeat (2) @(posedge ck);
    #1;
    chk_msb("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.lsb_q", 32'(q_l), 32'h0);
    @(negedge ck);
    rst = 1'b0;

    // Frame A5, then a frame aborted by ld_n after 3 bits, then 5A.
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    b = 8'hA5;
    for (int i = 7; i >= 1; i--) tbl.push_back(mk(1, 0, b[i], 0, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, b[0], 0, 0, 8'hA5, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 8'hA5, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 0, 0, 8'hA5, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'hA5, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'hA5, 0, 0, 0, 0));
    b = 8'h5A;
    for (int i = 7; i >= 1; i--) tbl.push_back(mk(1, 0, b[i], 0, 0, 8'hA5, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, b[0], 0, 0, 8'h5A, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 8'h5A, 0, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].ld_n, tbl[k].en_n, tbl[k].si, tbl[k].rd, tbl[k].clr);
      chk_msb($sformatf("vec%0d", k), tbl[k].q, tbl[k].qv, tbl[k].ovr, tbl[k].frm, tbl[k].busy);
    end

    // Bit order: stream 1,1,0,0,0,0,0,0.
    pulse_rst();
    send_byte(8'hC0, 1'b0, 1'b0);
    chk("order.msb_q", 32'(q_m), 32'hC0);
    chk("order.lsb_q", 32'(q_l), 32'h03);
    chk("order.lsb_q_valid", 32'(qv_l), 32'h1);
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Overrun: second word dropped while the first is unacknowledged.
    send_byte(8'h3C, 1'b0, 1'b0);
    chk_msb("ovr.first", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    chk_msb("ovr.drop", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_msb("ovr.clr", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_msb("ovr.ack", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    chk_msb("ovr.rd_same_edge", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b1);
    chk_msb("ovr.set_wins", 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_msb("ovr.clr_ack", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("ack.no_effect", 32'(qv_m), 32'h0);

    // Gapped enables: si carries the inverted bit on idle edges.
    b = 8'h96;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, 1'b0, b[i], 1'b0, 1'b0);
      step(1'b1, 1'b1, ~b[i], 1'b0, 1'b0);
    end
    chk_msb("gap.word", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_msb("ld_en.idle", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h81, 1'b0, 1'b0);
    chk_msb("ld_en.no_sample", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it silently.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("rst_mid.busy_before", 32'(busy_m), 32'h1);
    pulse_rst();
    chk_msb("rst_mid.after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk_msb("rst_mid.idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    chk_msb("rst_mid.next", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames with en_n held low and rd on every completion.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    for (int f = 0; f < 3; f++) begin
      b = words[f];
      for (int i = 7; i >= 0; i--) begin
        step(1'b1, 1'b0, b[i], (i == 0) ? 1'b1 : 1'b0, 1'b0);
        if (i == 7 && f > 0) chk($sformatf("b2b.busy%0d", f), 32'(busy_m), 32'h1);
      end
      chk_msb($sformatf("b2b.word%0d", f), words[f], 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
